// File: rtl/input_state.sv
// rtl/input_state.sv - player colour-entry round: compare presses against a latched sequence with an idle timeout
module input_state #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n_input,
    input  logic        en_input,
    input  logic [31:0] seq_in_input,
    input  logic [3:0]  round_ctr,
    input  logic [1:0]  colour_in,
    input  logic        colour_valid,
    output logic [1:0]  colour_echo,
    output logic        echo_oe,
    output logic        busy_input,
    output logic        complete_input,
    output logic        fail_input,
    output logic        timeout_input
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PASS, ST_FAIL} state_t;

    state_t      state_q, state_d;
    logic [31:0] seq_q, seq_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  pos_q, pos_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  echo_d;
    logic        echo_oe_d;
    logic        timeout_d;
    logic [1:0]  expected;

    assign expected = seq_q[{pos_q, 1'b0} +: 2];

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        n_d       = n_q;
        pos_d     = pos_q;
        timer_d   = timer_q;
        echo_d    = colour_echo;
        echo_oe_d = 1'b0;
        timeout_d = timeout_input;
        case (state_q)
            ST_IDLE: begin
                if (en_input) begin
                    seq_d     = seq_in_input;
                    n_d       = round_ctr;
                    pos_d     = 4'd0;
                    timer_d   = 16'd0;
                    timeout_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a press always takes priority over an expiring timer
                if (colour_valid) begin
                    echo_d    = colour_in;
                    echo_oe_d = 1'b1;
                    timer_d   = 16'd0;
                    if (colour_in == expected) begin
                        if (pos_q == n_q) begin
                            state_d = ST_PASS;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        state_d   = ST_FAIL;
                        timeout_d = 1'b0;
                    end
                end else if (timer_q >= TIMEOUT_CYCLES - 16'd1) begin
                    state_d   = ST_FAIL;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_PASS: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs are registered from the next-state decode so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n_input) begin
        if (!rst_n_input) begin
            state_q        <= ST_IDLE;
            seq_q          <= 32'd0;
            n_q            <= 4'd0;
            pos_q          <= 4'd0;
            timer_q        <= 16'd0;
            colour_echo    <= 2'b00;
            echo_oe        <= 1'b0;
            busy_input     <= 1'b0;
            complete_input <= 1'b0;
            fail_input     <= 1'b0;
            timeout_input  <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            n_q            <= n_d;
            pos_q          <= pos_d;
            timer_q        <= timer_d;
            colour_echo    <= echo_d;
            echo_oe        <= echo_oe_d;
            busy_input     <= (state_d != ST_IDLE);
            complete_input <= (state_d == ST_PASS);
            fail_input     <= (state_d == ST_FAIL);
            timeout_input  <= timeout_d;
        end
    end
endmodule

// File: tb/tb_input_state.sv
// tb/tb_input_state.sv - randomized and directed checks of input_state against a schedule-level model
module tb_input_state;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] seq_in = 32'd0;
    logic [3:0]  round_ctr = 4'd0;
    logic [1:0]  colour_in = 2'd0;
    logic        colour_valid = 1'b0;
    logic [1:0]  colour_echo;
    logic        echo_oe, busy, complete, fail, timeout;

    int total = 0;
    int bad = 0;
    int       gap_a [16];
    logic [1:0] col_a [16];

    input_state #(.TIMEOUT_CYCLES(16'(T))) dut (
        .clk(clk), .rst_n_input(rst_n), .en_input(en), .seq_in_input(seq_in),
        .round_ctr(round_ctr), .colour_in(colour_in), .colour_valid(colour_valid),
        .colour_echo(colour_echo), .echo_oe(echo_oe), .busy_input(busy),
        .complete_input(complete), .fail_input(fail), .timeout_input(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each press i follows gap_a[i] idle cycles; a gap of T or more times out after T idle cycles.
    task automatic run_round(input logic [31:0] seq, input logic [3:0] n, input bit noisy);
        bit         vld  [0:299];
        logic [1:0] colv [0:299];
        int cyc, e, p;
        bit pass, tmo;
        for (int c = 0; c < 300; c++) begin
            vld[c] = 1'b0;
            colv[c] = 2'd0;
        end
        cyc = 0; e = 0; pass = 1'b0; tmo = 1'b0;
        for (int i = 0; i <= int'(n); i++) begin
            if (gap_a[i] >= T) begin
                e = cyc + T - 1;
                tmo = 1'b1;
                break;
            end
            p = cyc + gap_a[i];
            vld[p] = 1'b1;
            colv[p] = col_a[i];
            if (col_a[i] != seq[2*i +: 2]) begin
                e = p;
                break;
            end
            if (i == int'(n)) begin
                e = p;
                pass = 1'b1;
                break;
            end
            cyc = p + 1;
        end

        en = 1'b1; seq_in = seq; round_ctr = n; colour_valid = 1'b0;
        @(posedge clk); #1;
        check("start_busy", busy, 1);
        check("start_tmo_clr", timeout, 0);
        for (int c = 0; c <= e + 1; c++) begin
            en = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                seq_in = $urandom;
                round_ctr = 4'($urandom);
            end
            if (c <= e) begin
                colour_valid = vld[c];
                colour_in = vld[c] ? colv[c] : 2'($urandom);
            end else begin
                colour_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                colour_in = 2'($urandom);
            end
            @(posedge clk); #1;
            check("echo_oe", echo_oe, (c <= e) && vld[c]);
            if (c <= e && vld[c]) check("echo_col", colour_echo, colv[c]);
            check("complete", complete, (c == e) && pass);
            check("fail", fail, (c == e) && !pass);
            check("busy", busy, c <= e);
            check("timeout", timeout, (c >= e) ? tmo : 1'b0);
        end
        en = 1'b0; colour_valid = 1'b1; colour_in = 2'($urandom);
        @(posedge clk); #1;
        check("idle_echo", echo_oe, 0);
        check("idle_busy", busy, 0);
        check("idle_tmo_hold", timeout, tmo);
        colour_valid = 1'b0;
    endtask

    task automatic set_presses(input logic [31:0] seq, input int g, input bit correct);
        for (int i = 0; i < 16; i++) begin
            gap_a[i] = g;
            col_a[i] = correct ? seq[2*i +: 2] : ~seq[2*i +: 2];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [3:0]  n;
        int r;
        bit exp_busy [7];
        bit exp_comp [7];

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_echo_oe", echo_oe, 0);
        check("rst_complete", complete, 0);
        check("rst_fail", fail, 0);
        check("rst_timeout", timeout, 0);
        check("rst_colour", colour_echo, 0);
        rst_n = 1'b1;

        s = 32'h0000_00E4;
        gap_a[0] = 0; gap_a[1] = 1; gap_a[2] = 0; gap_a[3] = 2;
        col_a[0] = 2'd0; col_a[1] = 2'd1; col_a[2] = 2'd2; col_a[3] = 2'd3;
        run_round(s, 4'd3, 1'b0);
        col_a[2] = 2'd3;
        run_round(s, 4'd3, 1'b0);

        set_presses(s, T, 1'b1);
        run_round(s, 4'd0, 1'b0);
        set_presses(s, T - 1, 1'b1);
        run_round(s, 4'd0, 1'b0);

        s = $urandom;
        set_presses(s, 0, 1'b1);
        run_round(s, 4'd15, 1'b1);

        s = 32'h0000_00E4;
        en = 1'b1; seq_in = s; round_ctr = 4'd3; colour_valid = 1'b0;
        @(posedge clk); #1;
        en = 1'b0; colour_valid = 1'b1; colour_in = 2'd0;
        @(posedge clk); #1;
        colour_in = 2'd1;
        @(posedge clk); #1;
        colour_valid = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_echo", echo_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_echo_oe", echo_oe, 0);
        check("arst_colour", colour_echo, 0);
        check("arst_complete", complete, 0);
        check("arst_fail", fail, 0);
        check("arst_timeout", timeout, 0);
        @(posedge clk); #1;
        check("arst_hold_busy", busy, 0);
        rst_n = 1'b1;
        set_presses(s, 0, 1'b1);
        run_round(s, 4'd3, 1'b0);

        for (int k = 0; k < 25; k++) begin
            s = $urandom;
            r = $urandom_range(0, 9);
            n = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 99);
                if (r < 70) gap_a[i] = $urandom_range(0, 2);
                else if (r < 85) gap_a[i] = T - 1;
                else if (r < 93) gap_a[i] = T;
                else gap_a[i] = $urandom_range(0, T + 3);
                col_a[i] = s[2*i +: 2];
                if ($urandom_range(0, 11) == 0) col_a[i] = col_a[i] ^ 2'($urandom_range(1, 3));
            end
            run_round(s, n, 1'($urandom_range(0, 1)));
        end

        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_comp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        en = 1'b1; seq_in = 32'd0; round_ctr = 4'd0; colour_valid = 1'b1; colour_in = 2'd0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check("hold_en_busy", busy, exp_busy[k]);
            check("hold_en_complete", complete, exp_comp[k]);
            if (k == 4) begin
                en = 1'b0;
                colour_valid = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_state.md
INPUT_STATE -- requirements
Module: input_state

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd50000, idle cycles allowed between presses before a round fails.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n_input  input  1  asynchronous, active-low reset.
REQ-004 en_input  input  1  start request for a player-entry round.
REQ-005 seq_in_input  input  32  16 colours packed LSB-first; colour k occupies bits [2k+1:2k].
REQ-006 round_ctr  input  4  value N means the player must enter N+1 colours.
REQ-007 colour_in  input  2  colour of the player press.
REQ-008 colour_valid  input  1  1-cycle strobe qualifying colour_in; pulses are already debounced.
REQ-009 colour_echo  output  2  last accepted colour, for LED feedback.
REQ-010 echo_oe  output  1  1-cycle pulse marking colour_echo valid.
REQ-011 busy_input  output  1  high while a round is in progress.
REQ-012 complete_input  output  1  1-cycle pulse: all N+1 colours were entered correctly.
REQ-013 fail_input  output  1  1-cycle pulse: a wrong colour or a timeout occurred.
REQ-014 timeout_input  output  1  qualifies fail_input: 1 = failure was caused by timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT, PASS and FAIL; all outputs are registered.
REQ-016 IDLE: when en_input=1, latch seq_in_input and round_ctr, clear pos (4-bit) and the timer, and go to WAIT on the next edge.
REQ-017 WAIT: busy_input=1; the timer increments every cycle that colour_valid=0.
REQ-018 WAIT with colour_valid=1: compare colour_in with latched bits [2*pos+1:2*pos]; echo colour_in and pulse echo_oe on the next cycle; clear the timer.
REQ-019 Match with pos != latched N: pos increments and the FSM stays in WAIT.
REQ-020 Match with pos == latched N: go to PASS.
REQ-021 Mismatch: go to FAIL with timeout_input=0.
REQ-022 Timer reaches TIMEOUT_CYCLES-1 with no press: go to FAIL with timeout_input=1.
REQ-023 A press in the same cycle as timer expiry SHALL win; it is evaluated per REQ-018 to REQ-021.
REQ-024 PASS: assert complete_input for exactly one cycle, then return to IDLE.
REQ-025 FAIL: assert fail_input for exactly one cycle, then return to IDLE.
REQ-026 timeout_input SHALL hold its value until the next round starts.
REQ-027 busy_input=1 in WAIT, PASS and FAIL; busy_input=0 in IDLE.
REQ-028 colour_valid in IDLE, PASS or FAIL SHALL be ignored: no echo, no state change.
REQ-029 en_input while busy SHALL be ignored; changes to seq_in_input or round_ctr mid-round have no effect.
REQ-030 With en_input held high, a new round starts on the first IDLE cycle after PASS or FAIL.
REQ-031 round_ctr=0 means a single press decides the round; round_ctr=15 uses all 16 colours with no pos wrap.
REQ-032 The timer SHALL saturate and never wrap; TIMEOUT_CYCLES SHALL be at least 2.

Reset
REQ-033 rst_n_input=0 SHALL immediately force state IDLE, pos=0 and timer=0.
REQ-034 rst_n_input=0 SHALL immediately force latched sequence=0, colour_echo=2'b00, echo_oe=0, busy_input=0, complete_input=0, fail_input=0 and timeout_input=0.
REQ-035 Reset asserted mid-round SHALL abort the round with no complete or fail pulse.
REQ-036 After reset deasserts, the first accepted en_input is evaluated on the next rising edge.

Verification
REQ-037 seq=32'h0000_00E4, N=3, presses 0,1,2,3 -> four echo_oe pulses; complete_input pulses 1 cycle after the 4th press; fail_input stays 0.
REQ-038 Same seq, presses 0,1,3 -> fail_input 1 cycle after the 3rd press; timeout_input=0; no complete_input.
REQ-039 TIMEOUT_CYCLES=8, N=0, no press -> fail_input with timeout_input=1, 8 cycles after entering WAIT.
REQ-040 TIMEOUT_CYCLES=8, correct press on the expiry cycle -> complete_input pulses; no fail_input.
REQ-041 Reset pulsed after 2 correct presses -> all outputs 0 at once; a fresh round then passes from pos 0.
REQ-042 Presses while IDLE, and en_input toggling mid-round -> no echo_oe, no extra rounds, round result unchanged.
